// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, start/busy/done handshake.
// Optional leading-zero blanking mask enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   shreg_q, shreg_d;
    logic [SW-1:0]   adj, shifted;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            done_q, done_d;

    // Add-3 on every digit field in parallel, then shift the whole register left.
    always_comb begin
        adj = shreg_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (shreg_q[WIDTH+4*i +: 4] >= 4'd5) begin
                adj[WIDTH+4*i +: 4] = shreg_q[WIDTH+4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[SW-2:0], 1'b0};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = {{BW{1'b0}}, bin};
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                shreg_d = shifted;
                if (cnt_q == LAST) begin
                    bcd_d   = shifted[SW-1 -: BW];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == CONV);
    assign done = done_q;
    assign bcd  = bcd_q;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              zero_above;

    // Digit 0 is never blanked so that a zero result still shows one "0".
    always_comb begin
        blank_d    = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (bcd_d[4*i +: 4] == 4'd0);
            blank_d[i] = zero_above;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, random values against a decimal
// reference model, and hand-written handshake/reset sequences.
module tb_bin2bcd_seq;

   localparam int WIDTH  = 16;
   localparam int DIGITS = 5;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] binIn;
   logic        busy;
   logic        done;
   logic [19:0] bcd;
   logic [4:0]  blank;

   int checks;
   int errors;

   typedef struct {
      logic [15:0] value;
      logic [19:0] expBcd;
      logic [4:0]  expBlank;
   } vector_t;

   vector_t vecs [12];

   bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (binIn),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .blank (blank)
   );

   // Free-running 10ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decimal reference: each digit is a plain quotient/remainder of the value
   function automatic logic [19:0] refBcd(input int v);
      logic [19:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // Digit i (i >= 1) is blank when the value is below 10^i
   function automatic logic [4:0] refBlank(input int v);
      logic [4:0] r;
      int p;
      r = '0;
      p = 10;
      for (int i = 1; i < 5; i++) begin
         r[i] = (v < p);
         p = p * 10;
      end
      return r;
   endfunction

   // Blank output only carries information when the feature is compiled in
   function automatic logic [4:0] effBlank(input logic [4:0] b);
`ifdef BIN2BCD_BLANK_EN
      return b;
`else
      return (b & 5'b00000);
`endif
   endfunction

   // Single comparison point: counts every check and reports each failure
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Start one conversion, scramble bin while busy, then check latency and result
   task automatic applyStimulus(input string tag, input logic [15:0] value,
                                input logic [19:0] expBcd, input logic [4:0] expBlank);
      int n;
      bit busyOk;
      @(negedge clk);
      binIn = value;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
      n      = 0;
      busyOk = 1'b1;
      while (done !== 1'b1 && n < 40) begin
         if (busy !== 1'b1) busyOk = 1'b0;
         binIn = 16'($urandom);
         @(negedge clk);
         n++;
      end
      checkOutput({tag, " latency"}, 32'(n), 32'(WIDTH));
      checkOutput({tag, " busy held"}, 32'(busyOk), 32'd1);
      checkOutput({tag, " bcd"}, 32'(bcd), 32'(expBcd));
      checkOutput({tag, " blank"}, 32'(blank), 32'(effBlank(expBlank)));
      checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput({tag, " done one cycle"}, 32'(done), 32'd0);
   endtask

   initial begin
      int n;
      int doneCount;
      bit bcdStable;
      logic [15:0] r;

      checks = 0;
      errors = 0;
      rst    = 1'b1;
      start  = 1'b0;
      binIn  = '0;

      vecs[0]  = '{16'hFFFF,  20'h65535, 5'b00000};
      vecs[1]  = '{16'd65025, 20'h65025, 5'b00000};
      vecs[2]  = '{16'd0,     20'h00000, 5'b11110};
      vecs[3]  = '{16'd200,   20'h00200, 5'b11000};
      vecs[4]  = '{16'd9,     20'h00009, 5'b11110};
      vecs[5]  = '{16'd10,    20'h00010, 5'b11100};
      vecs[6]  = '{16'd1000,  20'h01000, 5'b10000};
      vecs[7]  = '{16'd40000, 20'h40000, 5'b00000};
      vecs[8]  = '{16'd99,    20'h00099, 5'b11100};
      vecs[9]  = '{16'd10000, 20'h10000, 5'b00000};
      vecs[10] = '{16'd5,     20'h00005, 5'b11110};
      vecs[11] = '{16'd59999, 20'h59999, 5'b00000};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset bcd", 32'(bcd), 32'd0);
      checkOutput("reset blank", 32'(blank), 32'd0);
      rst = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 12; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].value, vecs[i].expBcd, vecs[i].expBlank);
      end

      // Random values against the decimal model
      for (int i = 0; i < 20; i++) begin
         r = 16'($urandom_range(0, 65535));
         applyStimulus($sformatf("rand%0d", i), r, refBcd(int'(r)), refBlank(int'(r)));
      end

      // Start while busy is ignored and produces no extra done pulse
      @(negedge clk);
      binIn = 16'd1234;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start     = 1'b0;
      doneCount = 0;
      n         = 0;
      for (int c = 1; c <= 30; c++) begin
         if (c == 5) begin
            start = 1'b1;
            binIn = 16'd9999;
         end else begin
            start = 1'b0;
            binIn = 16'($urandom);
         end
         @(negedge clk);
         if (done === 1'b1) begin
            doneCount++;
            if (n == 0) n = c;
         end
      end
      start = 1'b0;
      checkOutput("ignored start bcd", 32'(bcd), 32'h01234);
      checkOutput("ignored start done count", 32'(doneCount), 32'd1);
      checkOutput("ignored start latency", 32'(n), 32'(WIDTH));

      // Back-to-back: start in the done cycle is accepted
      @(negedge clk);
      binIn = 16'd65535;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("b2b first bcd", 32'(bcd), 32'h65535);
      binIn = 16'd42;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 1;
      bcdStable = 1'b1;
      while (done !== 1'b1 && n < 40) begin
         if (bcd !== 20'h65535) bcdStable = 1'b0;
         @(negedge clk);
         n++;
      end
      checkOutput("b2b bcd held during conv", 32'(bcdStable), 32'd1);
      checkOutput("b2b second latency", 32'(n), 32'(WIDTH + 1));
      checkOutput("b2b second bcd", 32'(bcd), 32'h00042);
      checkOutput("b2b second blank", 32'(blank), 32'(effBlank(5'b11100)));

      // Asynchronous reset mid-conversion aborts and clears outputs
      @(negedge clk);
      binIn = 16'd500;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort done", 32'(done), 32'd0);
      checkOutput("abort bcd", 32'(bcd), 32'd0);
      checkOutput("abort blank", 32'(blank), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      doneCount = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (done === 1'b1) doneCount++;
      end
      checkOutput("abort no done", 32'(doneCount), 32'd0);
      applyStimulus("after abort", 16'd7, 20'h00007, 5'b11110);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the bench can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
